aes_kat_bist: RTL and testbench
===============================

// Module: aes_kat_bist
// PURPOSE
//  Synthesizable known-answer self-test engine for the pipelined AES-128 core (top).
//  Issues a table of state/key vectors back-to-back, one per clock, and checks the
//  core's output a fixed LATENCY cycles later. Reports pass/fail, error count and the
//  first failing vector. Supports single-shot and continuous-loop modes, so it can act
//  as an on-chip activity/integrity monitor.
// PARAMETERS
//  DATA_W   128  width of state, key and out buses
//  LATENCY  21   clocks from vector applied (sampled by DUT) to matching dut_out valid; >=1
//  NUM_VEC  5    number of table entries used (1..8)
//  CNT_W    16   width of err_count and pass_count (saturating)
// PORTS
//  clk             in   1        rising-edge clock
//  rst             in   1        asynchronous, active-low reset
//  start           in   1        one-cycle pulse: begin a run (ignored unless IDLE or DONE)
//  loop_en         in   1        sampled at start: 1 = repeat table until abort
//  abort           in   1        end run: stop issuing, drain in-flight checks, go DONE
//  dut_state       out  DATA_W   plaintext to DUT
//  dut_key         out  DATA_W   key to DUT
//  dut_out         in   DATA_W   ciphertext from DUT
//  busy            out  1        high in ISSUE and DRAIN
//  done            out  1        high in DONE until next start
//  pass            out  1        valid when done: err_count==0 and >=1 check made
//  err_count       out  CNT_W    mismatches this run, saturates at all-ones
//  pass_count      out  CNT_W    completed error-free table passes, saturates
//  first_fail_vld  out  1        a mismatch has occurred this run
//  first_fail_idx  out  3        table index of first mismatch
// BEHAVIOUR
//  Reset: all outputs 0; dut_state/dut_key 0; FSM IDLE; delay line cleared.
//  FSM: IDLE -start-> ISSUE; ISSUE -(last idx & !loop) or abort-> DRAIN;
//   DRAIN -LATENCY cycles elapsed-> DONE; DONE -start-> ISSUE.
//  start clears err_count, pass_count, first_fail_*, done, pass in the same cycle.
//  ISSUE: each clock drive table[idx]; idx increments, wraps NUM_VEC-1 -> 0 in loop mode.
//  Outside ISSUE, dut_state/dut_key driven to 0.
//  Check pipeline: LATENCY-deep shift register of {valid, idx}; entry pushed valid in
//   every ISSUE cycle. When the head is valid, compare dut_out to expected[idx] that cycle.
//  Mismatch: err_count+1 (saturating); if !first_fail_vld, latch idx, set first_fail_vld.
//  pass_count +1 when the check for idx NUM_VEC-1 completes with no mismatch
//   since the last idx-0 check.
//  Abort: takes effect next edge; no new vector issued; in-flight checks still compared.
//   Abort in DRAIN/IDLE/DONE has no effect.
//  Simultaneous start and abort in IDLE: start wins, abort ignored.
//  start while busy: ignored.
//  DONE: pass = (err_count==0) && (any check made); done held.
//  Reset mid-run: immediate return to IDLE, counters cleared, no DONE.
// STRUCTURE
//  Package aes_kat_pkg:
//   - FSM state enum
//   - KAT_STATE[8], KAT_KEY[8], KAT_EXP[8] vector tables, with entries 0..4:
//     FIPS-197 App.B (3243f6a8.. / 2b7e1516.. -> 3925841d..);
//     App.C.1 (00112233.. / 00010203.. -> 69c4e0d8..);
//     0/0 -> 66e94bd4..; 0/1 -> 0545aad5..; 1/0 -> 58e2fcce..
//  One sub-module: kat_delay_line (param DEPTH, WIDTH; async active-low reset shift register).
// TESTING
//  - Real top, LATENCY=21, single run: done after 5+21 cycles, pass=1, err_count=0,
//    pass_count=1.
//  - Stub DUT = 21-cycle delay of expected XOR 1 on vector 2: err_count=1,
//    first_fail_idx=2, pass=0.
//  - Loop mode, abort after 23 issued vectors: busy drops 21 cycles after last issue;
//    pass_count=4; 23 checks made.
//  - Stub with latency 20 vs LATENCY=21: err_count=5, first_fail_idx=0.
//  - rst low during ISSUE: all outputs 0 asynchronously.
//    Next start gives a clean pass with counters from 0.
//  - start pulsed while busy and with abort in IDLE: run unaffected / starts normally.

Source files
------------

// File: rtl/aes_kat_pkg.sv
// ---------------------------------------------------------------------------
// aes_kat_pkg
//   Shared types and known-answer vector tables for the AES-128 KAT BIST.
//   - kat_fsm_e : run-control FSM states
//   - KAT_STATE / KAT_KEY / KAT_EXP : plaintext, key and expected ciphertext
//     for up to KAT_TBL vectors.
//   Entries 0..4 are the reference answers. Entries 5..7 mirror 0..2 so a
//   NUM_VEC of up to 8 still checks against valid ciphertexts.
// ---------------------------------------------------------------------------
package aes_kat_pkg;

   typedef enum logic [1:0] {
      KAT_IDLE  = 2'd0,
      KAT_ISSUE = 2'd1,
      KAT_DRAIN = 2'd2,
      KAT_DONE  = 2'd3
   } kat_fsm_e;

   localparam int KAT_TBL   = 8;
   localparam int KAT_IDX_W = 3;

   // 0: FIPS-197 App.B, 1: App.C.1, 2: zero/zero, 3: zero/key1, 4: one/zero
   localparam logic [127:0] KAT_STATE [KAT_TBL] = '{
      128'h3243f6a8885a308d313198a2e0370734,
      128'h00112233445566778899aabbccddeeff,
      128'h00000000000000000000000000000000,
      128'h00000000000000000000000000000000,
      128'h00000000000000000000000000000001,
      128'h3243f6a8885a308d313198a2e0370734,
      128'h00112233445566778899aabbccddeeff,
      128'h00000000000000000000000000000000
   };

   localparam logic [127:0] KAT_KEY [KAT_TBL] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'h000102030405060708090a0b0c0d0e0f,
      128'h00000000000000000000000000000000,
      128'h00000000000000000000000000000001,
      128'h00000000000000000000000000000000,
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'h000102030405060708090a0b0c0d0e0f,
      128'h00000000000000000000000000000000
   };

   localparam logic [127:0] KAT_EXP [KAT_TBL] = '{
      128'h3925841d02dc09fbdc118597196a0b32,
      128'h69c4e0d86a7b0430d8cdb78070b4c55a,
      128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
      128'h0545aad56da2a97c3663d1432a3d1c84,
      128'h58e2fccefa7e3061367f1d57a4e7455a,
      128'h3925841d02dc09fbdc118597196a0b32,
      128'h69c4e0d86a7b0430d8cdb78070b4c55a,
      128'h66e94bd4ef8a2c3b884cfa59ca342b2e
   };

endpackage

// File: rtl/kat_delay_line.sv
// ---------------------------------------------------------------------------
// kat_delay_line
//   Fixed-depth shift register. An entry written on one clock appears on
//   dout DEPTH clocks later, so it lines up with a DUT of DEPTH pipeline
//   registers sampled on the same edge.
//   Ports:
//     clk   in  rising-edge clock
//     rst   in  asynchronous active-low reset, clears every stage
//     din   in  WIDTH  entry pushed every clock
//     dout  out WIDTH  entry pushed DEPTH clocks earlier
// ---------------------------------------------------------------------------
module kat_delay_line #(
   parameter int DEPTH = 21,
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] sr [DEPTH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            sr[i] <= '0;
         end
      end else begin
         sr[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            sr[i] <= sr[i-1];
         end
      end
   end

   assign dout = sr[DEPTH-1];

endmodule

// File: rtl/aes_kat_bist.sv
// ---------------------------------------------------------------------------
// aes_kat_bist
//   Known-answer self-test engine for a pipelined AES-128 core. Streams the
//   KAT table into the core one vector per clock and checks each ciphertext
//   LATENCY clocks later. Single-shot or continuous-loop (until abort).
//   Ports:
//     clk, rst        clock; asynchronous active-low reset
//     start           pulse: begin a run (only from IDLE or DONE)
//     loop_en         captured at start: repeat the table until abort
//     abort           stop issuing, drain in-flight checks, then DONE
//     dut_state/key   vector to the core (zero outside ISSUE)
//     dut_out         ciphertext from the core
//     busy            ISSUE or DRAIN
//     done            run finished, held until next start
//     pass            done, no mismatches and at least one check made
//     err_count       saturating mismatch count for this run
//     pass_count      saturating count of clean complete table passes
//     first_fail_vld  a mismatch has been seen this run
//     first_fail_idx  table index of the first mismatch
// ---------------------------------------------------------------------------
module aes_kat_bist
   import aes_kat_pkg::*;
#(
   parameter int DATA_W  = 128,
   parameter int LATENCY = 21,
   parameter int NUM_VEC = 5,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              loop_en,
   input  logic              abort,
   output logic [DATA_W-1:0] dut_state,
   output logic [DATA_W-1:0] dut_key,
   input  logic [DATA_W-1:0] dut_out,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [CNT_W-1:0]  err_count,
   output logic [CNT_W-1:0]  pass_count,
   output logic              first_fail_vld,
   output logic [2:0]        first_fail_idx
);

   // Drain counter only has to hold 0..LATENCY-1.
   localparam int DCNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY);
   localparam logic [DCNT_W-1:0]    DCNT_LAST = DCNT_W'(LATENCY - 1);
   localparam logic [KAT_IDX_W-1:0] LAST_IDX  = KAT_IDX_W'(NUM_VEC - 1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   kat_fsm_e             st, st_nxt;
   logic [KAT_IDX_W-1:0] idx, idx_nxt;
   logic                 loop_q;
   logic [DCNT_W-1:0]    dcnt;
   logic                 start_ok;
   logic                 last_p0;
   logic                 vld_p0;
   logic                 vld_p1;
   logic [KAT_IDX_W-1:0] idx_p1;
   logic [DATA_W-1:0]    exp_p1;
   logic                 mism_p1;
   logic                 seg_ok;
   logic                 seg_now;
   logic                 any_chk;

   // ---- stage p0: run control and vector issue ----
   // A start that arrives while busy is dropped here, so it never clears
   // counters or reloads loop_q mid-run.
   assign start_ok = start && ((st == KAT_IDLE) || (st == KAT_DONE));
   assign last_p0  = (idx == LAST_IDX);
   assign vld_p0   = (st == KAT_ISSUE);

   always_comb begin
      st_nxt  = st;
      idx_nxt = idx;
      case (st)
         KAT_IDLE, KAT_DONE: begin
            if (start) begin
               st_nxt  = KAT_ISSUE;
               idx_nxt = '0;
            end
         end
         KAT_ISSUE: begin
            idx_nxt = last_p0 ? '0 : idx + KAT_IDX_W'(1);
            // The vector driven in the abort cycle is still issued.
            if (abort || (last_p0 && !loop_q)) begin
               st_nxt = KAT_DRAIN;
            end
         end
         KAT_DRAIN: begin
            if (dcnt == DCNT_LAST) begin
               st_nxt = KAT_DONE;
            end
         end
         default: st_nxt = KAT_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st     <= KAT_IDLE;
         idx    <= '0;
         loop_q <= 1'b0;
         dcnt   <= '0;
      end else begin
         st  <= st_nxt;
         idx <= idx_nxt;
         if (start_ok) begin
            loop_q <= loop_en;
         end
         dcnt <= (st == KAT_DRAIN) ? dcnt + DCNT_W'(1) : '0;
      end
   end

   assign dut_state = vld_p0 ? KAT_STATE[idx][DATA_W-1:0] : '0;
   assign dut_key   = vld_p0 ? KAT_KEY[idx][DATA_W-1:0]   : '0;

   // ---- stage p1: {valid, idx} delayed to line up with dut_out ----
   kat_delay_line #(
      .DEPTH (LATENCY),
      .WIDTH (1 + KAT_IDX_W)
   ) u_dly (
      .clk  (clk),
      .rst  (rst),
      .din  ({vld_p0, idx}),
      .dout ({vld_p1, idx_p1})
   );

   assign exp_p1  = KAT_EXP[idx_p1][DATA_W-1:0];
   assign mism_p1 = vld_p1 && (dut_out != exp_p1);
   // A table pass is clean when every check from idx 0 through the last
   // index matched; an idx-0 check restarts the segment.
   assign seg_now = ((idx_p1 == '0) ? 1'b1 : seg_ok) && !mism_p1;

   // ---- stage p2: result accumulation ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_count      <= '0;
         pass_count     <= '0;
         first_fail_vld <= 1'b0;
         first_fail_idx <= '0;
         seg_ok         <= 1'b0;
         any_chk        <= 1'b0;
      end else if (start_ok) begin
         err_count      <= '0;
         pass_count     <= '0;
         first_fail_vld <= 1'b0;
         first_fail_idx <= '0;
         seg_ok         <= 1'b0;
         any_chk        <= 1'b0;
      end else if (vld_p1) begin
         any_chk <= 1'b1;
         seg_ok  <= seg_now;
         if (mism_p1) begin
            err_count <= sat_inc(err_count);
            if (!first_fail_vld) begin
               first_fail_vld <= 1'b1;
               first_fail_idx <= idx_p1;
            end
         end
         if ((idx_p1 == LAST_IDX) && seg_now) begin
            pass_count <= sat_inc(pass_count);
         end
      end
   end

   assign busy = (st == KAT_ISSUE) || (st == KAT_DRAIN);
   assign done = (st == KAT_DONE);
   assign pass = done && (err_count == '0) && any_chk;

endmodule

// File: tb/tb_aes_kat_bist.sv
// ---------------------------------------------------------------------------
// tb_aes_kat_bist
//   Directed bench for aes_kat_bist. A behavioural stand-in for the AES core
//   looks the applied state/key up in the bench's own answer table, can flip
//   bit 0 for one chosen vector, and returns it after 21 (or 20) clocks.
// ---------------------------------------------------------------------------
module tb_aes_kat_bist;

   localparam int DW  = 128;
   localparam int LAT = 21;
   localparam int NV  = 5;
   localparam int CW  = 16;

   localparam logic [127:0] TV_PT [5] = '{
      128'h3243f6a8885a308d313198a2e0370734,
      128'h00112233445566778899aabbccddeeff,
      128'h00000000000000000000000000000000,
      128'h00000000000000000000000000000000,
      128'h00000000000000000000000000000001
   };
   localparam logic [127:0] TV_KEY [5] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'h000102030405060708090a0b0c0d0e0f,
      128'h00000000000000000000000000000000,
      128'h00000000000000000000000000000001,
      128'h00000000000000000000000000000000
   };
   localparam logic [127:0] TV_CT [5] = '{
      128'h3925841d02dc09fbdc118597196a0b32,
      128'h69c4e0d86a7b0430d8cdb78070b4c55a,
      128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
      128'h0545aad56da2a97c3663d1432a3d1c84,
      128'h58e2fccefa7e3061367f1d57a4e7455a
   };

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic           loop_en = 1'b0;
   logic           abort = 1'b0;
   logic [DW-1:0]  dut_state, dut_key, dut_out;
   logic           busy, done, pass;
   logic [CW-1:0]  err_count, pass_count;
   logic           first_fail_vld;
   logic [2:0]     first_fail_idx;

   int bad_idx  = -1;
   int stub_lat = 21;
   int n_chk    = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   int cyc;

   always #5 clk = ~clk;

   aes_kat_bist #(
      .DATA_W  (DW),
      .LATENCY (LAT),
      .NUM_VEC (NV),
      .CNT_W   (CW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .loop_en        (loop_en),
      .abort          (abort),
      .dut_state      (dut_state),
      .dut_key        (dut_key),
      .dut_out        (dut_out),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .err_count      (err_count),
      .pass_count     (pass_count),
      .first_fail_vld (first_fail_vld),
      .first_fail_idx (first_fail_idx)
   );

   // Stand-in AES core
   function automatic logic [127:0] stub_ct(input logic [127:0] s,
                                            input logic [127:0] k,
                                            input int bad);
      for (int i = 0; i < 5; i++) begin
         if (s == TV_PT[i] && k == TV_KEY[i]) begin
            return TV_CT[i] ^ ((i == bad) ? 128'd1 : 128'd0);
         end
      end
      return '0;
   endfunction

   logic [127:0] stub_sr [21];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 21; i++) stub_sr[i] <= '0;
      end else begin
         stub_sr[0] <= stub_ct(dut_state, dut_key, bad_idx);
         for (int i = 1; i < 21; i++) stub_sr[i] <= stub_sr[i-1];
      end
   end

   assign dut_out = (stub_lat == 20) ? stub_sr[19] : stub_sr[20];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Returns at the falling edge right after the start edge (issue cycle 0).
   task automatic run_start(input logic l, input logic ab);
      @(negedge clk);
      start   = 1'b1;
      loop_en = l;
      abort   = ab;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
   endtask

   // Counts falling edges after the start edge until done; optionally pulses
   // start (while busy) at cycle poke_at.
   task automatic wait_done(input int c0, input int poke_at, output int c);
      c = c0;
      while (done !== 1'b1 && c < 300) begin
         @(negedge clk);
         c++;
         start = (c == poke_at);
      end
      start = 1'b0;
   endtask

   // Loop run aborted in the cycle of issued vector n_issue; reports the
   // number of cycles from the abort edge until busy falls.
   task automatic loop_abort(input string tag, input int n_issue, output int drop);
      run_start(1'b1, 1'b0);
      chk({tag, "_err_clr"}, err_count, 0);
      chk({tag, "_ff_clr"}, first_fail_vld, 0);
      repeat (n_issue - 1) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk({tag, "_busy_drain"}, busy, 1);
      chk({tag, "_st_drain"}, dut_state, 0);
      chk({tag, "_key_drain"}, dut_key, 0);
      drop = 0;
      while (busy === 1'b1 && drop < 100) begin
         @(negedge clk);
         drop++;
      end
   endtask

   initial begin
      // Reset state
      #2 rst = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_err", err_count, 0);
      chk("rst_pcnt", pass_count, 0);
      chk("rst_ffv", first_fail_vld, 0);
      chk("rst_ffi", first_fail_idx, 0);
      chk("rst_st", dut_state, 0);
      chk("rst_key", dut_key, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // A: clean single run, start together with abort in IDLE
      run_start(1'b0, 1'b1);
      chk("a_busy", busy, 1);
      chk("a_st0", dut_state, TV_PT[0]);
      chk("a_key0", dut_key, TV_KEY[0]);
      @(negedge clk);
      chk("a_st1", dut_state, TV_PT[1]);
      chk("a_key1", dut_key, TV_KEY[1]);
      wait_done(1, 0, cyc);
      chk("a_lat", cyc, 26);
      chk("a_pass", pass, 1);
      chk("a_err", err_count, 0);
      chk("a_pcnt", pass_count, 1);
      chk("a_ffv", first_fail_vld, 0);

      // B: vector 2 corrupted; start and loop_en poked while busy
      bad_idx = 2;
      run_start(1'b0, 1'b0);
      chk("b_done_clr", done, 0);
      chk("b_pass_clr", pass, 0);
      chk("b_pcnt_clr", pass_count, 0);
      loop_en = 1'b1;
      wait_done(0, 10, cyc);
      chk("b_lat", cyc, 26);
      chk("b_err", err_count, 1);
      chk("b_ffv", first_fail_vld, 1);
      chk("b_ffi", first_fail_idx, 2);
      chk("b_pass", pass, 0);
      chk("b_pcnt", pass_count, 0);

      // C: clean loop, abort with the 23rd vector
      bad_idx = -1;
      loop_abort("c", 23, cyc);
      chk("c_drop", cyc, 21);
      chk("c_done", done, 1);
      chk("c_pass", pass, 1);
      chk("c_err", err_count, 0);
      chk("c_pcnt", pass_count, 4);

      // D: same loop with vector 2 corrupted: seen in five passes
      bad_idx = 2;
      loop_abort("d", 23, cyc);
      chk("d_drop", cyc, 21);
      chk("d_err", err_count, 5);
      chk("d_ffi", first_fail_idx, 2);
      chk("d_pcnt", pass_count, 0);
      chk("d_pass", pass, 0);

      // E: core one clock faster than LATENCY
      bad_idx  = -1;
      stub_lat = 20;
      run_start(1'b0, 1'b0);
      wait_done(0, 0, cyc);
      chk("e_lat", cyc, 26);
      chk("e_err", err_count, 5);
      chk("e_ffi", first_fail_idx, 0);
      chk("e_pass", pass, 0);
      chk("e_pcnt", pass_count, 0);
      stub_lat = 21;

      // F: reset in the middle of a loop run, then a clean run
      run_start(1'b1, 1'b0);
      repeat (29) @(negedge clk);
      chk("f_busy_pre", busy, 1);
      chk("f_pcnt_pre", pass_count, 1);
      chk("f_st_pre", dut_state, TV_PT[4]);
      rst = 1'b0;
      #1;
      chk("f_busy", busy, 0);
      chk("f_done", done, 0);
      chk("f_pcnt", pass_count, 0);
      chk("f_err", err_count, 0);
      chk("f_ffv", first_fail_vld, 0);
      chk("f_st", dut_state, 0);
      chk("f_key", dut_key, 0);
      @(negedge clk);
      rst = 1'b1;
      run_start(1'b0, 1'b0);
      wait_done(0, 0, cyc);
      chk("f2_lat", cyc, 26);
      chk("f2_pass", pass, 1);
      chk("f2_err", err_count, 0);
      chk("f2_pcnt", pass_count, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
